adcif: RTL and testbench

I2S receiver (ADC interface), the receive-side counterpart of the audio DAC interface. It samples an externally clocked Philips-format I2S stream (BCK, LRCK, DATA, all asynchronous to `clk`) and deserializes it into signed left/right word pairs. Each completed pair is presented with a one-cycle strobe. It sits between the board ADC/codec pins and the audio capture logic.

---
 rtl/adcif.sv | 99 +++++++++
 tb/tb_adcif.sv | 134 +++++++++++++
 2 files changed

// File: rtl/adcif.sv
// adcif: Philips I2S receiver; deserializes an external BCK/LRCK/DATA stream into left/right word pairs.
//   clk, rst      system clock, asynchronous active-high reset
//   i2s_bck       external bit clock (async to clk)
//   i2s_lrck      external word clock, 0 = left slot, 1 = right slot (async to clk)
//   i2s_data      external serial data, MSB first, valid at BCK rise (async to clk)
//   sample_valid  one-cycle strobe when a new pair is presented
//   left_data     last completed left word, held between strobes
//   right_data    last completed right word, held between strobes
//   locked        high while framed (LEFT or RIGHT)
//   short_slot    with sample_valid: a slot of the pair carried fewer than WIDTH bits
module adcif #(
   parameter int WIDTH   = 24,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i2s_bck,
   input  logic             i2s_lrck,
   input  logic             i2s_data,
   output logic             sample_valid,
   output logic [WIDTH-1:0] left_data,
   output logic [WIDTH-1:0] right_data,
   output logic             locked,
   output logic             short_slot
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;
   state_t state, state_nx;
   logic [2:0] bck_s;
   logic [1:0] lrck_s, data_s;
   logic lrck_prev, left_short, bck_rise, boundary, timeout, slot_short, commit_left, commit_pair;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] shreg, left_hold;
   logic [15:0] idle;
   assign bck_rise   = bck_s[1] & ~bck_s[2];
   assign boundary   = bck_rise & (lrck_s[1] != lrck_prev);
   // a BCK rise in the same cycle keeps the lock alive
   assign timeout    = !bck_rise && idle == 16'(TIMEOUT);
   assign slot_short = cnt < CW'(WIDTH);
   assign locked     = state != HUNT;
   always_comb begin
      state_nx    = state;
      commit_left = 1'b0;
      commit_pair = 1'b0;
      if (timeout)
         state_nx = HUNT;
      else if (boundary)
         unique case (state)
            HUNT:    state_nx = lrck_s[1] ? HUNT : LEFT;
            LEFT:    begin state_nx = RIGHT; commit_left = 1'b1; end
            RIGHT:   begin state_nx = LEFT;  commit_pair = 1'b1; end
            default: state_nx = HUNT;
         endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= HUNT;
      else     state <= state_nx;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bck_s        <= '0;
         lrck_s       <= '0;
         data_s       <= '0;
         lrck_prev    <= 1'b0;
         idle         <= '0;
         cnt          <= '0;
         shreg        <= '0;
         left_hold    <= '0;
         left_short   <= 1'b0;
         sample_valid <= 1'b0;
         left_data    <= '0;
         right_data   <= '0;
         short_slot   <= 1'b0;
      end else begin
         bck_s  <= {bck_s[1:0], i2s_bck};
         lrck_s <= {lrck_s[0], i2s_lrck};
         data_s <= {data_s[0], i2s_data};
         if (bck_rise) lrck_prev <= lrck_s[1];
         idle <= bck_rise ? '0 : (idle == 16'(TIMEOUT) ? idle : idle + 16'd1);
         // the bit at a boundary is the I2S one-bit delay and is dropped
         if (boundary) begin
            cnt   <= '0;
            shreg <= '0;
         end else if (bck_rise && state != HUNT && slot_short) begin
            shreg <= shreg | (data_s[1] ? MSB >> cnt : '0);
            cnt   <= cnt + CW'(1);
         end
         if (commit_left) begin
            left_hold  <= shreg;
            left_short <= slot_short;
         end
         sample_valid <= commit_pair;
         if (commit_pair) begin
            left_data  <= left_hold;
            right_data <= shreg;
            short_slot <= left_short | slot_short;
         end
      end
endmodule

// File: tb/tb_adcif.sv
// tb_adcif: directed self-checking bench for adcif with a pair-level reference model.
module tb_adcif;
   localparam int W  = 24;
   localparam int TO = 1023;
   logic clk = 1'b0, rst = 1'b1, bck = 1'b0, lrck = 1'b0, din = 1'b0;
   logic sample_valid, locked, short_slot;
   logic [W-1:0] left_data, right_data;
   typedef struct {logic [W-1:0] l; logic [W-1:0] r; logic s;} pair_t;
   pair_t expq[$];
   pair_t p;
   logic [W-1:0] held_l = '0, held_r = '0;
   logic held_s = 1'b0;
   int errs = 0, checks = 0;

   adcif #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .i2s_bck(bck), .i2s_lrck(lrck), .i2s_data(din),
      .sample_valid(sample_valid), .left_data(left_data), .right_data(right_data),
      .locked(locked), .short_slot(short_slot)
   );

   always #5 clk = ~clk;

   // word of n bits as it must appear in a WIDTH-bit output: truncated or zero-padded at the LSB end
   function automatic logic [W-1:0] align(input logic [63:0] w, input int n);
      return n >= W ? W'(w >> (n - W)) : W'(w << (W - n));
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic bit_out(input logic lr, input logic d);
      lrck = lr; din = d; bck = 1'b0; tick(4);
      bck = 1'b1; tick(4);
   endtask

   // one slot: the delay bit (deliberately the complement of the word's LSB), then n data bits MSB first
   task automatic slot(input logic lr, input logic [63:0] w, input int n);
      bit_out(lr, ~w[0]);
      for (int i = n - 1; i >= 0; i--) bit_out(lr, w[i]);
   endtask

   task automatic frame(input logic [63:0] lw, input int ln, input logic [63:0] rw, input int rn, input logic expect_out);
      slot(1'b0, lw, ln);
      slot(1'b1, rw, rn);
      if (expect_out) expq.push_back('{align(lw, ln), align(rw, rn), (ln < W) || (rn < W)});
   endtask

   always @(negedge clk) begin
      if (rst) begin
         held_l = '0; held_r = '0; held_s = 1'b0;
         chk("reset_outputs", {sample_valid, locked, short_slot, left_data, right_data}, '0);
      end else if (sample_valid) begin
         checks++;
         if (expq.size() == 0) begin
            errs++;
            $display("FAIL unexpected_strobe: got l=%h r=%h s=%b expected no strobe", left_data, right_data, short_slot);
         end else begin
            p = expq.pop_front();
            if (left_data !== p.l || right_data !== p.r || short_slot !== p.s) begin
               errs++;
               $display("FAIL pair: got l=%h r=%h s=%b expected l=%h r=%h s=%b", left_data, right_data, short_slot, p.l, p.r, p.s);
            end
            held_l = p.l; held_r = p.r; held_s = p.s;
         end
      end else if (left_data !== held_l || right_data !== held_r) begin
         checks++; errs++;
         $display("FAIL hold: got l=%h r=%h expected l=%h r=%h", left_data, right_data, held_l, held_r);
      end else checks++;
   end

   initial begin
      tick(3);
      chk("reset_locked", locked, 0);
      chk("reset_left", left_data, 0);
      rst = 1'b0;
      tick(2);
      frame(64'h555555, 24, 64'hAAAAAA, 24, 1'b0);
      chk("hunt_before_sync", locked, 0);
      frame(64'h123456, 24, 64'hABCDEF, 24, 1'b1);
      chk("locked_nominal", locked, 1);
      frame(64'h800000FF, 32, 64'h7FFFFF00, 32, 1'b1);
      chk("nominal_left", left_data, 64'h123456);
      chk("nominal_right", right_data, 64'hABCDEF);
      chk("nominal_short", short_slot, 0);
      frame(64'hBEEF, 16, 64'h1234, 16, 1'b1);
      chk("long_left", left_data, 64'h800000);
      chk("long_right", right_data, 64'h7FFFFF);
      // timeout in the middle of a left slot, then resume the same slot
      bit_out(1'b0, 1'b1);
      for (int i = 23; i >= 14; i--) bit_out(1'b0, 1'(24'h5A5A5A >> i));
      chk("short_left", left_data, 64'hBEEF00);
      chk("short_right", right_data, 64'h123400);
      chk("short_flag", short_slot, 1);
      chk("locked_before_stall", locked, 1);
      bck = 1'b0;
      tick(TO + 5);
      chk("locked_after_timeout", locked, 0);
      for (int i = 13; i >= 0; i--) bit_out(1'b0, 1'(24'h5A5A5A >> i));
      slot(1'b1, 64'h666666, 24);
      frame(64'h0F0F0F, 24, 64'hC3A5E1, 24, 1'b1);
      // reset during a right slot, released while that slot continues
      slot(1'b0, 64'h111111, 24);
      for (int i = 0; i < 6; i++) bit_out(1'b1, 1'(i));
      rst = 1'b1;
      #1;
      chk("rst_immediate_left", left_data, 0);
      chk("rst_immediate_locked", locked, 0);
      tick(2);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) bit_out(1'b1, 1'(~i));
      chk("hunt_mid_right", locked, 0);
      slot(1'b0, 64'h13579B, 24);
      chk("locked_after_resync", locked, 1);
      slot(1'b1, 64'h2468AC, 24);
      expq.push_back('{24'h13579B, 24'h2468AC, 1'b0});
      frame(64'hFEDCB, 20, 64'h987654, 24, 1'b1);
      chk("frame_a_left", left_data, 64'h13579B);
      bit_out(1'b0, 1'b0);
      tick(20);
      chk("frame_b_right", right_data, 64'h987654);
      chk("queue_drained", 64'(expq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
